// File: rtl/axis_frame_tx.sv
// AXI-Stream frame transmitter: a local FIFO feeds framed beats on the master port.
// A start command emits one frame of frame_len beats, with tlast marking the final beat.
module axis_frame_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                      m01_axis_aclk,
  input  logic                      m01_axis_areset,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      wr_full,
  output logic [ADDR_WIDTH:0]       fifo_count,
  output logic                      overflow,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      frame_len,
  output logic                      busy,
  output logic                      len_err,
  output logic [15:0]               frames_sent,
  output logic [DATA_WIDTH-1:0]     m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m01_axis_tstrb,
  output logic                      m01_axis_tvalid,
  output logic                      m01_axis_tlast,
  input  logic                      m01_axis_tready
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    overflow_q, overflow_d;
  state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    issued_q, issued_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [DATA_WIDTH/8-1:0] tstrb_q, tstrb_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [15:0]             frames_q, frames_d;
  logic                    len_err_q, len_err_d;
  logic                    wr_full_s;
  logic                    push_s;
  logic                    pop_s;

  // Next-state logic for the FIFO bookkeeping, frame FSM and output beat register.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    frames_d   = frames_q;
    len_err_d  = 1'b0;
    pop_s      = 1'b0;
    wr_full_s  = (count_q == FULL_CNT);
    push_s     = wr_en && !wr_full_s;
    overflow_d = overflow_q || (wr_en && wr_full_s);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            len_d    = frame_len;
            issued_d = '0;
            state_d  = SEND;
          end else begin
            len_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        // A new beat may replace the current one only once it has been accepted.
        if ((!tvalid_q || m01_axis_tready) && (count_q != '0) && (issued_q < len_q)) begin
          pop_s    = 1'b1;
          tdata_d  = mem_q[rd_ptr_q];
          tvalid_d = 1'b1;
          tlast_d  = (issued_q == (len_q - 1'b1));
          issued_d = issued_q + 1'b1;
        end else if (tvalid_q && m01_axis_tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end else begin
          tvalid_d = tvalid_q;
        end
        if (tvalid_q && m01_axis_tready && tlast_q) begin
          state_d  = IDLE;
          frames_d = frames_q + 16'd1;
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tstrb_d = tvalid_d ? '1 : '0;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    wr_ptr_d = push_s ? (wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + 1'b1) : rd_ptr_q;
  end

  // FIFO storage; contents need no reset since pointers and count gate every read.
  always_ff @(posedge m01_axis_aclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge m01_axis_aclk) begin
    if (m01_axis_areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      tdata_q    <= '0;
      tstrb_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      frames_q   <= '0;
      len_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      tdata_q    <= tdata_d;
      tstrb_q    <= tstrb_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      frames_q   <= frames_d;
      len_err_q  <= len_err_d;
    end
  end

  assign wr_full         = wr_full_s;
  assign fifo_count      = count_q;
  assign overflow        = overflow_q;
  assign busy            = (state_q == SEND);
  assign len_err         = len_err_q;
  assign frames_sent     = frames_q;
  assign m01_axis_tdata  = tdata_q;
  assign m01_axis_tstrb  = tstrb_q;
  assign m01_axis_tvalid = tvalid_q;
  assign m01_axis_tlast  = tlast_q;

endmodule
